// File: rtl/trng_pkg.sv
// Shared default constants for the TRNG post-processing blocks.
package trng_pkg;
    localparam int TRNG_WORD_W    = 32;
    localparam int RCT_CUTOFF_DEF = 32;
    localparam int APT_WINDOW_DEF = 1024;
    localparam int APT_CUTOFF_DEF = 840;
    localparam int FIFO_DEPTH_DEF = 8;
endpackage

// File: rtl/trng_word_fifo.sv
// First-word-fall-through word FIFO; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module trng_word_fifo
    import trng_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = TRNG_WORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             pop_ok_s;
    logic             push_ok_s;

    assign level     = wr_ptr_r - rd_ptr_r;
    assign full      = (level == (AW+1)'(DEPTH));
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];
    assign pop_ok_s  = pop && !empty;
    // A full FIFO still accepts a push when a pop frees the head slot.
    assign push_ok_s = push && (!full || pop_ok_s);

    // Pointer update; flush empties the FIFO without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/trng_conditioner.sv
// Raw TRNG bit post-processing: RCT/APT health tests, von Neumann debiasing,
// 32-bit word packing and FWFT buffering of the packed words.
module trng_conditioner
    import trng_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
    parameter int APT_WINDOW = APT_WINDOW_DEF,
    parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          clear,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic [31:0]                   word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          rct_fail,
    output logic                          apt_fail,
    output logic                          health_ok,
    output logic [15:0]                   words_dropped
);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int WW = $clog2(APT_WINDOW);
    localparam int CW = $clog2(APT_WINDOW + 1);
    localparam int PW = $clog2(TRNG_WORD_W);
    localparam logic [RW-1:0] RCT_MAX  = RW'(RCT_CUTOFF);
    localparam logic [CW-1:0] APT_MAX  = CW'(APT_CUTOFF);
    localparam logic [PW-1:0] PACK_END = PW'(TRNG_WORD_W - 1);

    logic                   seen_bit_r;
    logic                   last_bit_r;
    logic [RW-1:0]          run_len_r;
    logic [WW-1:0]          win_idx_r;
    logic                   ref_bit_r;
    logic [CW-1:0]          apt_cnt_r;
    logic                   pair_half_r;
    logic                   pair_first_r;
    logic [31:0]            shreg_r;
    logic [PW-1:0]          pack_cnt_r;
    logic                   rct_fail_r;
    logic                   apt_fail_r;
    logic                   health_ok_r;
    logic [15:0]            words_dropped_r;

    logic                   accept_s;
    logic [RW-1:0]          run_len_nxt_s;
    logic [CW-1:0]          apt_cnt_nxt_s;
    logic                   rct_trip_s;
    logic                   apt_trip_s;
    logic                   vn_emit_s;
    logic                   word_done_s;
    logic                   alarm_s;
    logic                   new_alarm_s;
    logic                   push_s;
    logic                   drop_s;
    logic                   flush_s;
    logic                   full_s;
    logic                   empty_s;
    logic [31:0]            word_s;

    assign accept_s    = enable && bit_valid && !clear;
    assign alarm_s     = rct_fail_r || apt_fail_r;
    assign new_alarm_s = (rct_trip_s || apt_trip_s) && !alarm_s;
    assign word_s      = {shreg_r[30:0], pair_first_r};
    // Words completed on or after the alarm cycle are discarded, not counted.
    assign push_s      = word_done_s && !alarm_s && !new_alarm_s;
    assign drop_s      = push_s && full_s && !(word_ready && !empty_s);
    assign flush_s     = clear || new_alarm_s;

    // Next-state of health counters, debias emit and word completion.
    always_comb begin
        run_len_nxt_s = run_len_r;
        apt_cnt_nxt_s = apt_cnt_r;
        rct_trip_s    = 1'b0;
        apt_trip_s    = 1'b0;
        vn_emit_s     = 1'b0;
        word_done_s   = 1'b0;
        if (accept_s) begin
            if (!seen_bit_r || (bit_in != last_bit_r)) begin
                run_len_nxt_s = RW'(1);
            end else if (run_len_r != RCT_MAX) begin
                run_len_nxt_s = run_len_r + 1'b1;
            end else begin
                run_len_nxt_s = run_len_r;
            end
            rct_trip_s = (run_len_nxt_s == RCT_MAX);
            if (win_idx_r == '0) begin
                apt_cnt_nxt_s = CW'(1);
            end else if (bit_in == ref_bit_r) begin
                apt_cnt_nxt_s = apt_cnt_r + 1'b1;
            end else begin
                apt_cnt_nxt_s = apt_cnt_r;
            end
            apt_trip_s  = (apt_cnt_nxt_s == APT_MAX);
            vn_emit_s   = pair_half_r && (pair_first_r != bit_in);
            word_done_s = vn_emit_s && (pack_cnt_r == PACK_END);
        end else begin
            run_len_nxt_s = run_len_r;
        end
    end

    // Conditioner state; clear outranks every other update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_bit_r      <= 1'b0;
            last_bit_r      <= 1'b0;
            run_len_r       <= '0;
            win_idx_r       <= '0;
            ref_bit_r       <= 1'b0;
            apt_cnt_r       <= '0;
            pair_half_r     <= 1'b0;
            pair_first_r    <= 1'b0;
            shreg_r         <= 32'h0000_0000;
            pack_cnt_r      <= '0;
            rct_fail_r      <= 1'b0;
            apt_fail_r      <= 1'b0;
            health_ok_r     <= 1'b1;
            words_dropped_r <= 16'h0000;
        end else if (clear) begin
            seen_bit_r      <= 1'b0;
            last_bit_r      <= 1'b0;
            run_len_r       <= '0;
            win_idx_r       <= '0;
            ref_bit_r       <= 1'b0;
            apt_cnt_r       <= '0;
            pair_half_r     <= 1'b0;
            pair_first_r    <= 1'b0;
            shreg_r         <= 32'h0000_0000;
            pack_cnt_r      <= '0;
            rct_fail_r      <= 1'b0;
            apt_fail_r      <= 1'b0;
            health_ok_r     <= 1'b1;
            words_dropped_r <= 16'h0000;
        end else if (accept_s) begin
            seen_bit_r  <= 1'b1;
            last_bit_r  <= bit_in;
            run_len_r   <= run_len_nxt_s;
            win_idx_r   <= win_idx_r + 1'b1;
            apt_cnt_r   <= apt_cnt_nxt_s;
            if (win_idx_r == '0) ref_bit_r <= bit_in;
            pair_half_r <= !pair_half_r;
            if (!pair_half_r) pair_first_r <= bit_in;
            if (vn_emit_s) begin
                shreg_r    <= word_s;
                pack_cnt_r <= pack_cnt_r + 1'b1;
            end
            rct_fail_r  <= rct_fail_r || rct_trip_s;
            apt_fail_r  <= apt_fail_r || apt_trip_s;
            health_ok_r <= !(rct_fail_r || rct_trip_s || apt_fail_r || apt_trip_s);
            if (drop_s && (words_dropped_r != 16'hFFFF)) begin
                words_dropped_r <= words_dropped_r + 16'h0001;
            end
        end
    end

    trng_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TRNG_WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_s),
        .push  (push_s),
        .wdata (word_s),
        .pop   (word_ready),
        .rdata (word_out),
        .level (fifo_level),
        .full  (full_s),
        .empty (empty_s)
    );

    assign word_valid    = !empty_s;
    assign rct_fail      = rct_fail_r;
    assign apt_fail      = apt_fail_r;
    assign health_ok     = health_ok_r;
    assign words_dropped = words_dropped_r;
endmodule

// File: tb/tb_trng_conditioner.sv
// Directed self-checking bench for trng_conditioner with hand-computed expectations.
module tb_trng_conditioner;
    logic        clk;
    logic        rst;
    logic        enable;
    logic        clear;
    logic        bit_in;
    logic        bit_valid;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  fifo_level;
    logic        rct_fail;
    logic        apt_fail;
    logic        health_ok;
    logic [15:0] words_dropped;

    int checks_cnt = 0;
    int errors_cnt = 0;

    trng_conditioner dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .clear         (clear),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .word_out      (word_out),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .fifo_level    (fifo_level),
        .rct_fail      (rct_fail),
        .apt_fail      (apt_fail),
        .health_ok     (health_ok),
        .words_dropped (words_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    // n bits of 1,0,1,0...: each 10 pair emits a 1
    task automatic send_alt(input int n);
        for (int i = 0; i < n; i++) send_bit((i % 2) == 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic pop_one();
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; bit_in = 1'b0;
        bit_valid = 1'b0; word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid",   word_valid,    32'd0);
        check_val("rst_level",   fifo_level,    32'd0);
        check_val("rst_rct",     rct_fail,      32'd0);
        check_val("rst_apt",     apt_fail,      32'd0);
        check_val("rst_health",  health_ok,     32'd1);
        check_val("rst_dropped", words_dropped, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic packing
        send_alt(63);
        check_val("pack_valid_early", word_valid, 32'd0);
        send_bit(1'b0);
        check_val("pack_valid", word_valid, 32'd1);
        check_val("pack_word",  word_out,   32'hFFFF_FFFF);
        check_val("pack_level", fifo_level, 32'd1);
        check_val("pack_health", health_ok, 32'd1);

        // Bits while enable is low are ignored
        bit_valid = 1'b1; enable = 1'b0; bit_in = 1'b1;
        repeat (64) @(posedge clk);
        #1;
        bit_valid = 1'b0;
        check_val("disabled_level", fifo_level, 32'd1);
        pop_one();
        check_val("pop_empty_valid", word_valid, 32'd0);
        pop_one();
        check_val("pop_empty_level", fifo_level, 32'd0);

        // Pair discard: 00,11,01 repeated emits one 0 per 6 raw bits
        do_clear();
        for (int r = 0; r < 32; r++) begin
            send_bit(1'b0); send_bit(1'b0);
            send_bit(1'b1); send_bit(1'b1);
            send_bit(1'b0); send_bit(1'b1);
        end
        check_val("discard_valid", word_valid, 32'd1);
        check_val("discard_word",  word_out,   32'h0000_0000);
        check_val("discard_rct",   rct_fail,   32'd0);
        check_val("discard_apt",   apt_fail,   32'd0);

        // RCT trip with one word stored
        do_clear();
        send_alt(64);
        for (int i = 0; i < 31; i++) send_bit(1'b1);
        check_val("rct_pre_fail",  rct_fail,   32'd0);
        check_val("rct_pre_level", fifo_level, 32'd1);
        send_bit(1'b1);
        check_val("rct_fail",   rct_fail,   32'd1);
        check_val("rct_level",  fifo_level, 32'd0);
        check_val("rct_valid",  word_valid, 32'd0);
        check_val("rct_health", health_ok,  32'd0);
        send_alt(64);
        check_val("rct_discard_level",   fifo_level,    32'd0);
        check_val("rct_discard_dropped", words_dropped, 32'd0);

        // Clear mid-word with alarm set
        send_alt(10);
        do_clear();
        check_val("clr_rct",     rct_fail,      32'd0);
        check_val("clr_health",  health_ok,     32'd1);
        check_val("clr_level",   fifo_level,    32'd0);
        check_val("clr_dropped", words_dropped, 32'd0);
        send_alt(62);
        check_val("clr_word_early", word_valid, 32'd0);
        send_alt(2);
        check_val("clr_word_valid", word_valid, 32'd1);
        check_val("clr_word",       word_out,   32'hFFFF_FFFF);

        // APT trip: 7 ones then a zero, from window start
        do_clear();
        for (int i = 0; i < 958; i++) send_bit((i % 8) != 7);
        check_val("apt_pre_fail",  apt_fail,   32'd0);
        check_val("apt_pre_level", fifo_level, 32'd3);
        send_bit(1'b1);
        check_val("apt_fail",   apt_fail,   32'd1);
        check_val("apt_rct",    rct_fail,   32'd0);
        check_val("apt_level",  fifo_level, 32'd0);
        check_val("apt_health", health_ok,  32'd0);

        // FIFO overflow
        do_clear();
        send_alt(9 * 64);
        check_val("ovf_level",   fifo_level,    32'd8);
        check_val("ovf_dropped", words_dropped, 32'd1);
        send_alt(63);
        word_ready = 1'b1;
        send_bit(1'b0);
        word_ready = 1'b0;
        check_val("ovf_pushpop_level",   fifo_level,    32'd8);
        check_val("ovf_pushpop_dropped", words_dropped, 32'd1);

        // Asynchronous reset pulse between clock edges
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("arst_level",   fifo_level,    32'd0);
        check_val("arst_valid",   word_valid,    32'd0);
        check_val("arst_dropped", words_dropped, 32'd0);
        check_val("arst_health",  health_ok,     32'd1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_alt(64);
        check_val("post_rst_valid", word_valid, 32'd1);
        check_val("post_rst_word",  word_out,   32'hFFFF_FFFF);
        check_val("post_rst_level", fifo_level, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
